// File: rtl/way_predictor_conf.sv
// Per-set way predictor: saturating confidence with hysteresis,
// registered lookup, sequential flush FSM and accuracy statistics.
module way_predictor_conf #(
  parameter int NUM_SETS    = 64,
  parameter int NUM_WAYS    = 4,
  parameter int INDEX_BITS  = $clog2(NUM_SETS),
  parameter int WAY_BITS    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int CONF_BITS   = 2,
  parameter int CONF_THRESH = 2,
  parameter int STAT_BITS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [INDEX_BITS-1:0] req_index,
  output logic                  pred_valid,
  output logic [WAY_BITS-1:0]   pred_way,
  output logic                  pred_confident,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_hit,
  input  logic [WAY_BITS-1:0]   upd_way,
  input  logic                  flush_req,
  output logic                  busy,
  output logic                  flush_done,
  input  logic                  stats_clr,
  output logic [STAT_BITS-1:0]  stat_correct,
  output logic [STAT_BITS-1:0]  stat_wrong
);

  localparam int PTR_W = INDEX_BITS + 1;
  localparam logic [CONF_BITS-1:0] CMAX = {CONF_BITS{1'b1}};
  localparam logic [STAT_BITS-1:0] SMAX = {STAT_BITS{1'b1}};
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SETS - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [WAY_BITS-1:0]    way_q  [NUM_SETS];
  logic [CONF_BITS-1:0]   conf_q [NUM_SETS];

  logic                   pred_valid_q;
  logic [WAY_BITS-1:0]    pred_way_q;
  logic                   pred_conf_q;
  logic                   busy_q;
  logic                   flush_done_q;
  logic [STAT_BITS-1:0]   corr_q, corr_d;
  logic [STAT_BITS-1:0]   wrong_q, wrong_d;

  logic                   way_ok;
  logic                   upd_en;
  logic                   same_way;
  logic [WAY_BITS-1:0]    e_way;
  logic [CONF_BITS-1:0]   e_conf;
  logic [WAY_BITS-1:0]    way_d;
  logic [CONF_BITS-1:0]   conf_d;
  logic                   req_conf;

  always_comb begin
    way_ok   = {1'b0, upd_way} < (WAY_BITS+1)'(NUM_WAYS);
    upd_en   = (state_q == IDLE) && upd_valid && upd_hit && way_ok;
    e_way    = way_q[upd_index];
    e_conf   = conf_q[upd_index];
    same_way = (e_way == upd_way);
    way_d    = e_way;
    conf_d   = e_conf;
    if (same_way) begin
      conf_d = (e_conf == CMAX) ? CMAX : e_conf + CONF_BITS'(1);
    end else if (e_conf != '0) begin
      // Hysteresis: a confident entry must be worn down before it moves.
      conf_d = e_conf - CONF_BITS'(1);
    end else begin
      way_d  = upd_way;
      conf_d = CONF_BITS'(1);
    end
  end

  always_comb begin
    corr_d  = corr_q;
    wrong_d = wrong_q;
    if (stats_clr) begin
      corr_d  = '0;
      wrong_d = '0;
    end else if (upd_en) begin
      if (same_way && corr_q != SMAX) corr_d = corr_q + STAT_BITS'(1);
      if (!same_way && wrong_q != SMAX) wrong_d = wrong_q + STAT_BITS'(1);
    end
  end

  assign req_conf = {1'b0, conf_q[req_index]} >= (CONF_BITS+1)'(CONF_THRESH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        way_q[i]  <= '0;
        conf_q[i] <= '0;
      end
      state_q      <= IDLE;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_way_q   <= '0;
      pred_conf_q  <= 1'b0;
      corr_q       <= '0;
      wrong_q      <= '0;
    end else begin
      flush_done_q <= 1'b0;
      corr_q       <= corr_d;
      wrong_q      <= wrong_d;
      pred_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            pred_valid_q <= 1'b1;
            pred_way_q   <= way_q[req_index];
            pred_conf_q  <= req_conf;
          end
          if (upd_en) begin
            way_q[upd_index]  <= way_d;
            conf_q[upd_index] <= conf_d;
          end
          if (flush_req) begin
            state_q <= FLUSH;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FLUSH: begin
          way_q[ptr_q[INDEX_BITS-1:0]]  <= '0;
          conf_q[ptr_q[INDEX_BITS-1:0]] <= '0;
          ptr_q <= ptr_q + PTR_W'(1);
          if (ptr_q == PTR_LAST) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_way       = pred_way_q;
  assign pred_confident = pred_conf_q;
  assign busy           = busy_q;
  assign flush_done     = flush_done_q;
  assign stat_correct   = corr_q;
  assign stat_wrong     = wrong_q;

endmodule

// File: tb/tb_way_predictor_conf.sv
// Directed bench for way_predictor_conf (4-bit stats to reach saturation).
module tb_way_predictor_conf;

  localparam int NS = 64;
  localparam int SB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [5:0]    req_index;
  logic          pred_valid;
  logic [1:0]    pred_way;
  logic          pred_confident;
  logic          upd_valid;
  logic [5:0]    upd_index;
  logic          upd_hit;
  logic [1:0]    upd_way;
  logic          flush_req;
  logic          busy;
  logic          flush_done;
  logic          stats_clr;
  logic [SB-1:0] stat_correct;
  logic [SB-1:0] stat_wrong;

  int n_vec = 0;
  int n_err = 0;

  way_predictor_conf #(.NUM_SETS(NS), .NUM_WAYS(4), .STAT_BITS(SB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_index(req_index),
    .pred_valid(pred_valid), .pred_way(pred_way),
    .pred_confident(pred_confident),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_hit(upd_hit), .upd_way(upd_way),
    .flush_req(flush_req), .busy(busy), .flush_done(flush_done),
    .stats_clr(stats_clr),
    .stat_correct(stat_correct), .stat_wrong(stat_wrong)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd(int idx, int w, logic hit = 1'b1);
    upd_valid = 1'b1;
    upd_hit   = hit;
    upd_index = 6'(idx);
    upd_way   = 2'(w);
    tick();
    upd_valid = 1'b0;
    upd_hit   = 1'b0;
  endtask

  task automatic look(int idx);
    req_valid = 1'b1;
    req_index = 6'(idx);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_pred(string tag, int w, logic c);
    chk({tag, "_v"}, 32'(pred_valid), 32'd1);
    chk({tag, "_way"}, 32'(pred_way), 32'(w));
    chk({tag, "_conf"}, 32'(pred_confident), 32'(c));
  endtask

  initial begin
    int cnt;
    int bad_pv;
    rst_n = 1'b0; req_valid = 1'b0; req_index = '0;
    upd_valid = 1'b0; upd_index = '0; upd_hit = 1'b0; upd_way = '0;
    flush_req = 1'b0; stats_clr = 1'b0;
    #1;
    tick(); tick();
    chk("rst_pv", 32'(pred_valid), 0);
    chk("rst_way", 32'(pred_way), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(flush_done), 0);
    chk("rst_corr", 32'(stat_correct), 0);
    chk("rst_wrong", 32'(stat_wrong), 0);
    rst_n = 1'b1;

    look(5);
    expect_pred("look5", 0, 1'b0);
    tick();
    chk("idle_pv", 32'(pred_valid), 0);
    chk("hold_way", 32'(pred_way), 0);

    // set 7 trained to way 3: conf 1,2,3,3
    upd(7, 3); look(7); expect_pred("tr1", 3, 1'b0);
    upd(7, 3); look(7); expect_pred("tr2", 3, 1'b1);
    upd(7, 3); look(7); expect_pred("tr3", 3, 1'b1);
    upd(7, 3); look(7); expect_pred("tr4", 3, 1'b1);
    chk("tr_corr", 32'(stat_correct), 3);
    chk("tr_wrong", 32'(stat_wrong), 1);

    // hysteresis: conf 2,1,0 keeps way 3, then moves to way 1
    upd(7, 1); look(7); expect_pred("hy1", 3, 1'b1);
    upd(7, 1); look(7); expect_pred("hy2", 3, 1'b0);
    upd(7, 1); look(7); expect_pred("hy3", 3, 1'b0);
    upd(7, 1); look(7); expect_pred("hy4", 1, 1'b0);
    upd(7, 1); look(7); expect_pred("hy5", 1, 1'b1);
    chk("hy_wrong", 32'(stat_wrong), 5);
    chk("hy_corr", 32'(stat_correct), 4);
    upd(7, 2, 1'b0);
    look(7); expect_pred("miss_ign", 1, 1'b1);
    chk("miss_wrong", 32'(stat_wrong), 5);

    // read-before-write on set 9
    req_valid = 1'b1; req_index = 6'd9;
    upd(9, 2);
    req_valid = 1'b0;
    expect_pred("rbw_old", 0, 1'b0);
    look(9); expect_pred("rbw_new", 2, 1'b0);
    chk("rbw_wrong", 32'(stat_wrong), 6);

    // train boundary sets 0 and 63
    upd(0, 1); upd(0, 1); upd(63, 2);
    look(0); expect_pred("s0", 1, 1'b1);
    look(63); expect_pred("s63", 2, 1'b0);
    chk("pre_corr", 32'(stat_correct), 5);
    chk("pre_wrong", 32'(stat_wrong), 8);

    // flush with a same-cycle update, which must still count
    flush_req = 1'b1;
    upd(63, 2);
    flush_req = 1'b0;
    chk("fl_busy0", 32'(busy), 1);
    chk("fl_corr", 32'(stat_correct), 6);
    cnt = 0;
    bad_pv = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (pred_valid) bad_pv++;
      req_valid = 1'b1; req_index = 6'd0;
      upd_valid = 1'b1; upd_hit = 1'b1; upd_index = 6'd0; upd_way = 2'd1;
      flush_req = (cnt == 10);
      tick();
      if (busy) chk("fl_nodone", 32'(flush_done), 0);
    end
    req_valid = 1'b0; upd_valid = 1'b0; upd_hit = 1'b0; flush_req = 1'b0;
    chk("fl_cycles", 32'(cnt), 64);
    chk("fl_done", 32'(flush_done), 1);
    chk("fl_pv_drop", 32'(bad_pv), 0);
    chk("fl_corr_kept", 32'(stat_correct), 6);
    tick();
    chk("fl_done_once", 32'(flush_done), 0);
    chk("fl_not_queued", 32'(busy), 0);
    look(0); expect_pred("fl_s0", 0, 1'b0);
    look(63); expect_pred("fl_s63", 0, 1'b0);
    look(7); expect_pred("fl_s7", 0, 1'b0);

    // reset at ptr==20 aborts the flush silently
    upd(3, 2);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (20) tick();
    chk("ab_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(flush_done), 0);
    chk("ab_wrong", 32'(stat_wrong), 0);
    tick();
    chk("ab_done2", 32'(flush_done), 0);

    // stat_correct saturation at 4'hF
    upd(3, 2);
    repeat (16) upd(3, 2);
    chk("sat_corr", 32'(stat_correct), 15);
    upd(3, 2);
    chk("sat_hold", 32'(stat_correct), 15);
    stats_clr = 1'b1;
    upd(3, 2);
    stats_clr = 1'b0;
    chk("clr_corr", 32'(stat_correct), 0);
    chk("clr_wrong", 32'(stat_wrong), 0);
    upd(3, 2);
    chk("post_clr", 32'(stat_correct), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
